qmult: RTL and testbench
========================

Name: qmult

Overview:
- Pipelined signed fixed-point multiplier used as the multiply stage of the convolution units (e.g. pconv_unit_c1).
- Takes a stream of N-bit two's-complement operand pairs (activation × weight) and emits the full-precision 32-bit signed product with a valid flag.
- Emits a one-cycle end flag when a burst of valid products finishes.
- Performs no fractional rescaling; downstream logic adds bias and applies the right shift.

Parameters:
- N, 16, operand width in bits, two's complement; legal range 2..16 so that 2N ≤ 32.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous reset, active-high. The codebase name is kept; despite the suffix, 1 = reset.
- ce, input, 1, clock enable, active high; pipeline advances only when 1.
- input_vld, input, 1, operand pair valid, active high.
- multiplicand_din, input, N, signed operand A.
- multiplier_din, input, N, signed operand B.
- product_dout, output, 32, signed product A*B, sign-extended from 2N bits to 32.
- product_dout_vld, output, 1, product_dout is valid this cycle.
- product_end, output, 1, single-cycle pulse marking the end of a valid burst.

Behaviour:
- Reset (rst_n=1, asynchronous): all pipeline registers, product_dout, product_dout_vld and product_end go to 0 immediately. They stay 0 while reset is held.
- Reset mid-burst: in-flight products are discarded. No product_end is generated for the aborted burst.
- Pipeline, fixed 2-cycle latency counted in ce=1 cycles.
  - Stage 1 registers A, B and input_vld.
  - Stage 2 registers the signed product and its valid bit.
  - Operands sampled at edge k appear on product_dout with product_dout_vld=1 after edge k+1.
- Throughput: one product per ce=1 cycle; back-to-back valid inputs are accepted with no bubbles.
- Arithmetic:
  - product = $signed(A) * $signed(B), exact 2N-bit result, sign-extended to 32 bits.
  - No rounding, saturation or Q shift.
  - Corner case: (-2^(N-1)) * (-2^(N-1)) = 2^(2N-2), which is representable and must not overflow.
- Invalid slots:
  - When the stage-2 valid bit is 0, product_dout is forced to 0.
  - Operand values are don't-care when input_vld=0.
- ce=0: all registers hold, outputs hold their values, and no new inputs are sampled. This includes product_dout_vld: a held valid is not a new product. Consumers must qualify with ce.
- product_end:
  - Asserted for exactly one ce=1 cycle, on the cycle after the last product of a burst, i.e. the first cycle product_dout_vld is 0 after having been 1.
  - Computed as registered (previous product_dout_vld & ~current valid).
  - A burst of length 1 still yields one product_end.
  - If a new burst starts right at the gap, product_end still pulses once for the previous burst.
- Simultaneous events: product_end and a new product_dout_vld cannot coincide for a single-cycle gap; the gap cycle carries product_end.

Decomposition:
- Shared package (nn_pkg): the constant PRODUCT_W = 32 and the default data width N = 16, for use by qmult and the pconv units.
- No sub-modules needed. Optionally split out a generic sign-extending register stage, qmult_pipe_reg; a single flat module is acceptable.

Test Plan:
- Reset: rst_n=1 asserted asynchronously mid-cycle with a valid burst in flight -> all outputs 0 immediately; after release with input_vld=0, outputs stay 0 and product_end never pulses.
- Basic signed products (N=16), ce=1, one pair per cycle: A=3,B=5 -> 15; A=-3,B=5 -> 0xFFFFFFF1; A=-32768,B=-32768 -> 0x40000000; A=32767,B=-32768 -> 0xC0008000. Each result appears 2 cycles after input, with vld=1.
- Back-to-back burst of 4 valid pairs then input_vld=0 -> 4 consecutive vld cycles with the correct products, then exactly one product_end pulse on the following cycle, and product_dout=0.
- ce gating: drive a valid pair, drop ce for 3 cycles, restore -> outputs frozen during ce=0; result appears after 2 ce=1 edges, with no duplicate or lost products.
- Gapped bursts: valid pattern 1,1,0,1,0 -> products in the same pattern with 2-cycle delay; product_end pulses once after each burst (two pulses total).
- Random regression: 10k random signed pairs with random input_vld and ce -> compare against a software model of a 2-stage enabled pipeline with sign-extended products.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths for the multiply stage and the pconv units
package nn_pkg;

  // Full-precision product width handed to the accumulate/bias stage
  localparam int PRODUCT_W = 32;

  // Default operand width (activation and weight), two's complement
  localparam int DATA_W = 16;

endpackage : nn_pkg

// File: rtl/qmult.sv
// rtl/qmult.sv - two-stage pipelined signed multiplier with burst-end flag
module qmult
  import nn_pkg::*;
#(
  // Operand width; must stay within 2..16 so the exact product fits PRODUCT_W
  parameter int N = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,            // active-high despite the name
  input  logic                 ce,
  input  logic                 input_vld,
  input  logic [N-1:0]         multiplicand_din,
  input  logic [N-1:0]         multiplier_din,
  output logic [PRODUCT_W-1:0] product_dout,
  output logic                 product_dout_vld,
  output logic                 product_end
);

  logic signed [N-1:0]     a_s1;
  logic signed [N-1:0]     b_s1;
  logic                    vld_s1;

  logic signed [2*N-1:0]   a_ext;
  logic signed [2*N-1:0]   b_ext;
  logic signed [2*N-1:0]   prod_full;
  logic [PRODUCT_W-1:0]    prod_ext;

  // Operands are widened to 2N before multiplying so the most-negative
  // squared case (2^(2N-2)) is computed exactly with no overflow.
  assign a_ext     = (2*N)'(a_s1);
  assign b_ext     = (2*N)'(b_s1);
  assign prod_full = a_ext * b_ext;
  assign prod_ext  = PRODUCT_W'(prod_full);

  // Stage 1: capture the operand pair and its valid bit
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_s1   <= '0;
      b_s1   <= '0;
      vld_s1 <= 1'b0;
    end else if (ce) begin
      a_s1   <= multiplicand_din;
      b_s1   <= multiplier_din;
      vld_s1 <= input_vld;
    end
  end

  // Stage 2: register the product (zeroed in empty slots) and the burst-end pulse
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      product_dout     <= '0;
      product_dout_vld <= 1'b0;
      product_end      <= 1'b0;
    end else if (ce) begin
      product_dout     <= vld_s1 ? prod_ext : '0;
      product_dout_vld <= vld_s1;
      // End fires on the first empty slot following a valid one
      product_end      <= product_dout_vld & ~vld_s1;
    end
  end

endmodule : qmult

// File: tb/tb_qmult.sv
// tb/tb_qmult.sv - scoreboard bench for qmult with random regression
module tb_qmult;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        input_vld;
  logic [15:0] multiplicand_din;
  logic [15:0] multiplier_din;
  logic [31:0] product_dout;
  logic        product_dout_vld;
  logic        product_end;

  int checks   = 0;
  int failures = 0;
  int end_cnt  = 0;

  logic [31:0] exp_q[$];
  logic        hist[$];
  logic        adv = 1'b0;

  logic [31:0] last_prod = '0;
  logic        last_vld  = 1'b0;
  logic        last_end  = 1'b0;

  qmult #(.N(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ce               (ce),
    .input_vld        (input_vld),
    .multiplicand_din (multiplicand_din),
    .multiplier_din   (multiplier_din),
    .product_dout     (product_dout),
    .product_dout_vld (product_dout_vld),
    .product_end      (product_end)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reset discards everything in flight; the slot history restarts as empty
  always @(posedge rst_n) begin
    exp_q.delete();
    hist = '{1'b0, 1'b0, 1'b0};
  end

  // Record what the DUT samples on each enabled edge
  always @(posedge clk) begin
    if (!rst_n && ce) begin
      hist.push_back(input_vld);
      if (hist.size() > 3) void'(hist.pop_front());
      if (input_vld) exp_q.push_back(model(multiplicand_din, multiplier_din));
      adv = 1'b1;
    end else begin
      adv = 1'b0;
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the scoreboard
  always @(negedge clk) begin
    logic ev;
    logic ee;
    if (rst_n) begin
      chk("rst_prod", product_dout, 32'h0);
      chk("rst_vld", {31'b0, product_dout_vld}, 32'h0);
      chk("rst_end", {31'b0, product_end}, 32'h0);
    end else if (adv) begin
      ev = hist[hist.size()-2];
      ee = hist[hist.size()-3] & ~hist[hist.size()-2];
      chk("vld", {31'b0, product_dout_vld}, {31'b0, ev});
      chk("end", {31'b0, product_end}, {31'b0, ee});
      if (product_end) end_cnt++;
      if (product_dout_vld) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
        else chk("prod", product_dout, exp_q.pop_front());
      end else begin
        chk("idle_prod", product_dout, 32'h0);
      end
    end else begin
      chk("hold_prod", product_dout, last_prod);
      chk("hold_vld", {31'b0, product_dout_vld}, {31'b0, last_vld});
      chk("hold_end", {31'b0, product_end}, {31'b0, last_end});
    end
    last_prod = product_dout;
    last_vld  = product_dout_vld;
    last_end  = product_end;
  end

  task automatic cyc(input logic c, input logic v, input int a, input int b);
    ce               = c;
    input_vld        = v;
    multiplicand_din = 16'(a);
    multiplier_din   = 16'(b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    rst_n = 1'b1;
    ce = 1'b0;
    input_vld = 1'b0;
    multiplicand_din = '0;
    multiplier_din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_prod", product_dout, 32'h0);
    chk("reset_vld", {31'b0, product_dout_vld}, 32'h0);
    rst_n = 1'b0;

    // Basic signed products and the most-negative corner cases
    cyc(1, 1, 3, 5);
    cyc(1, 1, -3, 5);
    chk("p_3x5", product_dout, 32'd15);
    cyc(1, 1, -32768, -32768);
    chk("p_m3x5", product_dout, 32'hFFFF_FFF1);
    cyc(1, 1, 32767, -32768);
    chk("p_min_sq", product_dout, 32'h4000_0000);
    cyc(1, 0, 0, 0);
    chk("p_max_min", product_dout, 32'hC000_8000);
    cyc(1, 0, 0, 0);
    chk("basic_end", {31'b0, product_end}, 32'h1);
    chk("basic_end_prod", product_dout, 32'h0);
    repeat (2) cyc(1, 0, 0, 0);

    // Back-to-back burst of four, exactly one end pulse
    e0 = end_cnt;
    for (int i = 0; i < 4; i++) cyc(1, 1, $urandom, $urandom);
    repeat (4) cyc(1, 0, 0, 0);
    chk("burst4_ends", 32'(end_cnt - e0), 32'd1);

    // ce gating: three stalled edges between sample and result
    cyc(1, 1, 7, -9);
    repeat (3) cyc(0, 0, 1, 1);
    cyc(1, 0, 0, 0);
    chk("ce_prod", product_dout, 32'hFFFF_FFC1);
    chk("ce_vld", {31'b0, product_dout_vld}, 32'h1);
    repeat (3) cyc(1, 0, 0, 0);

    // Gapped bursts 1,1,0,1,0 give two end pulses
    e0 = end_cnt;
    cyc(1, 1, 100, -2);
    cyc(1, 1, -5, -6);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1234, 4321);
    cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    chk("gap_ends", 32'(end_cnt - e0), 32'd2);

    // Asynchronous reset mid-burst: outputs clear at once, no end pulse
    e0 = end_cnt;
    for (int i = 0; i < 3; i++) cyc(1, 1, $urandom, $urandom);
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_prod", product_dout, 32'h0);
    chk("async_vld", {31'b0, product_dout_vld}, 32'h0);
    repeat (2) cyc(1, 1, 9, 9);
    rst_n = 1'b0;
    repeat (4) cyc(1, 0, 0, 0);
    chk("abort_ends", 32'(end_cnt - e0), 32'd0);

    // Random regression with random valid and clock enable
    for (int i = 0; i < 10000; i++) begin
      int a;
      int b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 15) == 0) a = -32768;
      if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, a, b);
    end
    repeat (4) cyc(1, 0, 0, 0);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_qmult
